// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 4-tap FIR sequencer: owns delay line, coefficients and accumulator,
// and drives one shared external multiplier and adder, one tap per cycle.
module fir_mac_sequencer #(
    parameter int unsigned   TAPS     = 4,
    parameter int unsigned   N        = 8,
    parameter int unsigned   W        = 16,
    parameter logic [N-1:0]  COEF_RST = 8'h20,
    localparam int unsigned  KW       = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coef_we,
    input  logic [KW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy,
    output logic [N-1:0]  mul_a,
    output logic [N-1:0]  mul_b,
    input  logic [W-1:0]  mul_p,
    output logic [W-1:0]  add_a,
    output logic [W-1:0]  add_b,
    input  logic [W-1:0]  add_s
);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [W-1:0]    acc;
    logic [N-1:0]    x    [TAPS];
    logic [N-1:0]    coef [TAPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            k     <= '0;
            acc   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x[i]    <= '0;
                coef[i] <= COEF_RST;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    // Write lands on the same edge as an accept, so it applies to that sample.
                    if (coef_we && (32'(coef_addr) < TAPS)) begin
                        coef[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x[i] <= x[i-1];
                        end
                        x[0]  <= in_data;
                        acc   <= '0;
                        k     <= '0;
                        state <= StMac;
                    end
                end
                StMac: begin
                    acc <= add_s;
                    if (k == KW'(TAPS - 1)) begin
                        state <= StOut;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        // in_ready is also masked by reset since the state flops already read IDLE then.
        in_ready  = (state == StIdle) && !reset;
        out_valid = (state == StOut);
        busy      = (state != StIdle);
        out_data  = (state == StOut) ? acc : '0;
        mul_a     = '0;
        mul_b     = '0;
        add_a     = '0;
        add_b     = '0;
        if (state == StMac) begin
            mul_a = x[k];
            mul_b = coef[k];
            add_a = acc;
            add_b = mul_p;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: vector table, corner sequences and random
// samples/coefficients checked against a sum-of-products reference model.
module tb_fir_mac_sequencer;

    localparam int TAPS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p, add_a, add_b, add_s;
    logic signed [15:0] bias;

    int errors = 0;
    int checks = 0;

    // Reference state: delay line (index 0 newest) and coefficients.
    logic [7:0] mx [TAPS];
    logic [7:0] mb [TAPS];

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [7:0]  sample;
        logic [15:0] expect_out;
    } vec_t;
    vec_t tbl [17];

    fir_mac_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s)
    );

    // Shared arithmetic units; bias = 1 models the approximate multiplier.
    assign mul_p = $signed(mul_a) * $signed(mul_b) + bias;
    assign add_s = add_a + add_b;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int partial(input int upto);
        int s = 0;
        for (int j = 0; j < upto; j++) begin
            s += int'($signed(mx[j])) * int'($signed(mb[j])) + int'(bias);
        end
        return s & 16'hFFFF;
    endfunction

    function automatic logic [15:0] model_out();
        return 16'(partial(TAPS));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mx[i] = 8'h00;
            mb[i] = 8'h20;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mul_a", int'(mul_a), 0);
        chk("rst_add_a", int'(add_a), 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        mb[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic accept(input logic [7:0] s, input logic we, input logic [1:0] a,
                          input logic [7:0] d);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_data = s;
        coef_we = we; coef_addr = a; coef_data = d;
        if (we) mb[a] = d;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = s;
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
    endtask

    // Called at the first negedge after the accept edge. hold < 0 leaves out_ready low.
    task automatic wait_result(input logic [15:0] exp, input int hold, input string tag);
        int lat = 0;
        out_ready = (hold == 0);
        while (!out_valid && lat < 12) begin
            if (lat < TAPS) begin
                chk({tag, "_mul_a"}, int'(mul_a), int'(mx[lat]));
                chk({tag, "_mul_b"}, int'(mul_b), int'(mb[lat]));
                chk({tag, "_add_a"}, int'(add_a), partial(lat));
                chk({tag, "_in_ready"}, int'(in_ready), 0);
            end
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, lat, TAPS);
        chk({tag, "_data"}, int'(out_data), int'(exp));
        chk({tag, "_idle_mul_a"}, int'(mul_a), 0);
        if (hold >= 0) begin
            repeat (hold) @(negedge clk);
            if (hold > 0) chk({tag, "_held"}, int'(out_valid), 1);
            out_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_drained"}, int'(out_valid), 0);
        end
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int r = first; r <= last; r++) begin
            accept(tbl[r].sample, tbl[r].we, tbl[r].addr, tbl[r].data);
            wait_result(tbl[r].expect_out, 0, $sformatf("%s%0d", tag, r));
        end
    endtask

    initial begin
        logic [15:0] exp_bp;
        tbl[0]  = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd128};
        tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd256};
        tbl[2]  = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd384};
        tbl[3]  = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd512};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 8'd10,  16'd10};
        tbl[5]  = '{1'b0, 2'd0, 8'h00, 8'd0,   16'd20};
        tbl[6]  = '{1'b0, 2'd0, 8'h00, 8'd0,   16'd30};
        tbl[7]  = '{1'b0, 2'd0, 8'h00, 8'd0,   16'd40};
        tbl[8]  = '{1'b1, 2'd0, 8'd5,  8'd10,  16'd50};
        tbl[9]  = '{1'b0, 2'd0, 8'h00, 8'h80,  16'h4000};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 8'h80,  16'h8000};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 8'h80,  16'hC000};
        tbl[12] = '{1'b0, 2'd0, 8'h00, 8'h80,  16'h0000};
        tbl[13] = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd132};
        tbl[14] = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd260};
        tbl[15] = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd388};
        tbl[16] = '{1'b0, 2'd0, 8'h00, 8'd4,   16'd516};

        bias = '0; in_data = '0; coef_addr = '0; coef_data = '0;
        do_reset();
        run_rows(0, 3, "dflt");

        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(2'(i), 8'(i + 1));
        run_rows(4, 8, "coef");

        // Backpressure: result held 10 cycles with a sample pending.
        out_ready = 1'b0;
        accept(8'd3, 1'b0, 2'd0, 8'h00);
        exp_bp = model_out();
        wait_result(exp_bp, -1, "bp");
        in_valid = 1'b1; in_data = 8'd77;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), int'(exp_bp));
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("bp_next_busy", int'(busy), 1);
        in_valid = 1'b0;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = 8'd77;
        wait_result(model_out(), 0, "bp_next");

        // Coefficient write during MAC must be dropped.
        accept(8'd9, 1'b0, 2'd0, 8'h00);
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = 8'h55;
        wait_result(model_out(), 0, "drop1");
        accept(8'd0, 1'b0, 2'd0, 8'h00);
        wait_result(model_out(), 0, "drop2");

        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(2'(i), 8'h80);
        run_rows(9, 12, "wrap");

        // Reset in the second MAC cycle.
        accept(8'd5, 1'b0, 2'd0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        accept(8'd4, 1'b0, 2'd0, 8'h00);
        wait_result(16'd128, 0, "midrst");

        do_reset();
        bias = 16'sd1;
        run_rows(13, 16, "approx");
        bias = '0;

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_coef(2'($urandom_range(0, 3)), 8'($urandom));
            end
            accept(8'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                   8'($urandom));
            wait_result(model_out(), int'($urandom_range(0, 3)), $sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed controller for a 4-tap signed FIR filter. It owns the sample delay line, the coefficient registers and the accumulator. It drives one external shared 8x8 multiplier and one external 16-bit adder, one tap per cycle, so that any approximate multiplier/adder pair from the library can be evaluated under a single sequencer. It sits between the sample source (valid/ready) and the filter-output consumer (valid/ready).

## Interface
- TAPS, 4, number of taps; tap counter width is clog2(TAPS)
- N, 8, sample and coefficient width (signed)
- W, 16, accumulator and output width (signed)
- COEF_RST, 8'h20, reset value of every coefficient (moving average)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index
- coef_data  in  N  coefficient value
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid && in_ready at posedge
- in_data  in  N  signed sample
- out_valid  out  1  filter result available
- out_ready  in  1  consumer accepts result
- out_data  out  W  signed filter result
- busy  out  1  high in MAC and OUT states
- mul_a, mul_b  out  N  multiplier operands (sample, coefficient)
- mul_p  in  W  multiplier product (combinational from mul_a/mul_b)
- add_a, add_b  out  W  adder operands (accumulator, product)
- add_s  in  W  adder sum (combinational)

## Operation
- Reset:
  - state IDLE; delay line x[0..TAPS-1] = 0; acc = 0; coefficients b[k] = COEF_RST; tap counter k = 0.
  - Outputs: out_valid = 0, out_data = 0, in_ready = 0 while reset is high, mul_*/add_* = 0.
- FSM states:
  - IDLE: in_ready = 1. On accept:
    - shift x[k] <= x[k-1] and x[0] <= in_data;
    - acc <= 0, k <= 0;
    - go to MAC.
  - MAC: drive mul_a = x[k], mul_b = b[k], add_a = acc, add_b = mul_p, and register acc <= add_s.
    - If k == TAPS-1, go to OUT; otherwise k <= k+1.
  - OUT: out_valid = 1, out_data = acc. When out_ready is high, go to IDLE.
- Datapath ports outside MAC: mul_a, mul_b, add_a and add_b are all 0.
- Ordering: x[0] is the newest sample, i.e. the one just accepted.
- Arithmetic:
  - Products and sums are taken exactly as returned on mul_p and add_s.
  - No saturation; the accumulator wraps modulo 2^W.
  - out_data is the raw accumulator.
- Coefficient writes:
  - Take effect only in IDLE; writes in MAC or OUT are dropped silently.
  - A write and a sample accept on the same IDLE edge: the new coefficient applies to that sample.
- Reset mid-operation: the sample in flight is discarded. out_valid drops immediately (asynchronous), and all state returns to reset values, coefficients included.

## Timing
- Accept edge E0. MAC occupies the cycles after E0..E(TAPS-1); acc is final at edge E(TAPS).
- out_valid rises in the cycle after E(TAPS): 4 cycles after the accept edge for TAPS = 4.
- out_valid, out_data and the FSM state hold while out_ready is low. in_ready stays 0 throughout MAC and OUT.
- With out_ready held high, OUT lasts 1 cycle, then IDLE lasts at least 1 cycle.
  - Maximum throughput is one sample per TAPS+2 cycles.
- in_ready, out_valid and busy are decoded from state registers only. No combinational path from in_valid or out_ready to any output.
- mul_p and add_s must settle within one cycle; the sequencer inserts no wait states.

## Test plan
All scenarios use exact multiplier/adder models unless stated otherwise.
- **Reset defaults:** after reset (all coefficients 0x20), feed samples 4,4,4,4 with out_ready = 1 -> out_data 128, 256, 384, 512; each out_valid appears 4 cycles after its accept.
- **Coefficient load:** in IDLE write b0..b3 = 1,2,3,4, then feed 10,0,0,0 -> out_data 10, 20, 30, 40. A write on the same edge as the accept of 10 with b0 = 5 -> first output 50.
- **Backpressure:** hold out_ready = 0 for 10 cycles in OUT with in_valid = 1 -> out_valid and out_data stable, in_ready = 0, no sample consumed. Release -> exactly one result transfers, and the next accept happens 1 cycle later.
- **Wrap:** all coefficients 0x80 (-128), samples -128 x4 -> out_data 0x4000, 0x8000, 0xC000, 0x0000.
- **Reset mid-operation and dropped writes:**
  - A coef_we during MAC is dropped.
  - Assert reset in the 2nd MAC cycle -> out_valid = 0 and busy = 0 immediately. Next sample 4 -> out_data 128 (delay line and coefficients at reset values).
- **Port sequencing:** use an approximate model with mul_p = a*b + 1.
  - mul_a/mul_b carry (x0,b0)..(x3,b3) on consecutive cycles.
  - For samples 4,4,4,4 with reset coefficients, each output is the exact result + 4: 132, 260, 388, 516.
